// File: rtl/tick_enable_gen.sv
// tick_enable_gen: turns a run/stop button, a single-step button and a divide
// value into one-cycle enable pulses for the downstream event counter.
// Build option TICK_GEN_DEBOUNCE_EN: when defined, each synchronised button
// level must stay stable for DB_CYCLES cycles before it is accepted; when
// undefined the synchronised level is used directly and DB_CYCLES is ignored.
module tick_enable_gen #(
  parameter int DIV_WIDTH = 16,
  parameter int DB_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 run_btn,
  input  logic                 step_btn,
  output logic                 enable,
  output logic                 running
);

  // A zero-length debounce window would never accept a level change.
  if (DB_CYCLES < 1) begin : g_db_cycles_check
    $error("tick_enable_gen: DB_CYCLES must be at least 1");
  end

  logic run_meta, run_sync;
  logic step_meta, step_sync;
  logic run_db, step_db;
  logic run_db_d, step_db_d;
  logic run_press, step_press;

  // Two-flop synchronisers for the raw, asynchronous button inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_meta  <= 1'b0;
      run_sync  <= 1'b0;
      step_meta <= 1'b0;
      step_sync <= 1'b0;
    end else begin
      run_meta  <= run_btn;
      run_sync  <= run_meta;
      step_meta <= step_btn;
      step_sync <= step_meta;
    end
  end

`ifdef TICK_GEN_DEBOUNCE_EN
  localparam int DB_CW = $clog2(DB_CYCLES + 1);
  localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DB_CYCLES - 1);

  logic [DB_CW-1:0] run_cnt, step_cnt;

  // Run button debounce: count consecutive cycles of disagreement with the
  // accepted level; accept the new level once the window has elapsed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_db  <= 1'b0;
      run_cnt <= '0;
    end else if (run_sync != run_db) begin
      if (run_cnt == DB_LAST) begin
        run_db  <= run_sync;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end else begin
      run_cnt <= '0;
    end
  end

  // Step button debounce, same filter as the run button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_db  <= 1'b0;
      step_cnt <= '0;
    end else if (step_sync != step_db) begin
      if (step_cnt == DB_LAST) begin
        step_db  <= step_sync;
        step_cnt <= '0;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end else begin
      step_cnt <= '0;
    end
  end
`else
  assign run_db  = run_sync;
  assign step_db = step_sync;
`endif

  // Rising-edge detect on the accepted levels; releases produce nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_db_d   <= 1'b0;
      step_db_d  <= 1'b0;
      run_press  <= 1'b0;
      step_press <= 1'b0;
    end else begin
      run_db_d   <= run_db;
      step_db_d  <= step_db;
      run_press  <= run_db & ~run_db_d;
      step_press <= step_db & ~step_db_d;
    end
  end

  // state   | meaning
  // ST_STOP | idle, enable low; run_press starts RUN, step_press issues STEP
  // ST_RUN  | prescaler counts, enable pulses every div_value+1 cycles
  // ST_STEP | the single step pulse cycle; always returns to ST_STOP
  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [DIV_WIDTH-1:0] presc, presc_nx;
  logic                 enable_nx;

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_STOP;
      presc   <= '0;
      enable  <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      presc   <= presc_nx;
      enable  <= enable_nx;
      running <= (state_nx == ST_RUN);
    end
  end

  // Next-state, prescaler and enable decode. The >= compare lets a lowered
  // div_value fire immediately instead of wrapping through the full range.
  always_comb begin
    state_nx  = state;
    presc_nx  = presc;
    enable_nx = 1'b0;
    unique case (state)
      ST_STOP: begin
        if (run_press) begin
          state_nx = ST_RUN;
          presc_nx = '0;
        end else if (step_press) begin
          state_nx  = ST_STEP;
          enable_nx = 1'b1;
        end
      end
      ST_RUN: begin
        if (run_press) begin
          state_nx = ST_STOP;
          presc_nx = '0;
        end else if (presc >= div_value) begin
          enable_nx = 1'b1;
          presc_nx  = '0;
        end else begin
          presc_nx = presc + 1'b1;
        end
      end
      ST_STEP: begin
        state_nx = ST_STOP;
      end
      default: begin
        state_nx = ST_STOP;
        presc_nx = '0;
      end
    endcase
  end

endmodule
